// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run controller.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_RST,
    RUN,
    HALTED,
    TIMEOUT
  } run_state_t;

  localparam int RESET_CYCLES_DEF = 5;
  localparam int MAX_CYCLES_DEF   = 2000;

endpackage

// File: rtl/cpu_run_wdog_cnt.sv
// Saturating RUN-cycle counter with clear, enable and
// terminal-count flag at MAX_CYCLES-1.
module cpu_run_wdog_cnt #(
  parameter int MAX_CYCLES = 2000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(MAX_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && count != TOP)
      count <= count + 1'b1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: CPU reset sequencing, cycle budget, halt detect.
// Optional CPU_RUN_AUTOSTART_EN: start a run on the first edge after reset.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cpu_halt,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_N = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int HW     = $clog2(HOLD_N + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_N - 1);

  run_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          go;
  logic          rearm;
  logic          cnt_en;
  logic          tc;

`ifdef CPU_RUN_AUTOSTART_EN
  logic arm;

  // One-shot pseudo start for the first edge out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      arm <= 1'b1;
    else
      arm <= 1'b0;
  end

  assign go = start | arm;
`else
  assign go = start;
`endif

  assign rearm  = go && (state == IDLE ||
                         state == HALTED ||
                         state == TIMEOUT);
  assign cnt_en = (state == RUN) && !cpu_halt;

  cpu_run_wdog_cnt #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (rearm),
    .en    (cnt_en),
    .count (cycle_count),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE, HALTED, TIMEOUT: begin
          if (go) begin
            state     <= HOLD_RST;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            timed_out <= 1'b0;
            hold_cnt  <= '0;
          end
        end
        HOLD_RST: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end
        end
        RUN: begin
          // Halt takes priority over the budget limit
          if (cpu_halt) begin
            state     <= HALTED;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (tc) begin
            state     <= TIMEOUT;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
